// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-back arbiter for the RV32I register file. Merges single-cycle ALU
//   results and long-latency load results onto the single register-file write
//   port. It also keeps a pending-destination scoreboard so that decode stalls
//   on RAW and WAW hazards against outstanding loads.
//
//   Optional build macro: WB_BYPASS_EN adds forwarding outputs
//   (o_fwd1_valid, o_fwd2_valid, o_fwd_data). With these, decode can take the
//   value being written this cycle instead of stalling on it.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_issue_valid       load issuing this cycle (accepted when !o_stall)
//   i_issue_rd_addr     load destination register
//   i_rs1_addr/rs2_addr decode source registers
//   o_stall             decode must hold, and the issue is not accepted
//   i_alu_*             ALU result (never back-pressured)
//   i_mem_*, o_mem_ready memory result, transferred when valid & ready
//   o_rw/o_rd_addr/o_rd registered register-file write port
//   o_pending           scoreboard, one bit per architectural register
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGISTER = 32,
  parameter int BUF_DEPTH    = 2,
  localparam int AW          = $clog2(NUM_REGISTER)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_issue_valid,
  input  logic [AW-1:0]           i_issue_rd_addr,
  input  logic [AW-1:0]           i_rs1_addr,
  input  logic [AW-1:0]           i_rs2_addr,
  output logic                    o_stall,
  input  logic                    i_alu_valid,
  input  logic [AW-1:0]           i_alu_rd_addr,
  input  logic [DATA_WIDTH-1:0]   i_alu_data,
  input  logic                    i_mem_valid,
  input  logic [AW-1:0]           i_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  output logic                    o_mem_ready,
  output logic                    o_rw,
  output logic [AW-1:0]           o_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd,
  output logic [NUM_REGISTER-1:0] o_pending
`ifdef WB_BYPASS_EN
  ,
  output logic                    o_fwd1_valid,
  output logic                    o_fwd2_valid,
  output logic [DATA_WIDTH-1:0]   o_fwd_data
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Memory handshake: a result transfers on a rising clock edge when
  // i_mem_valid and o_mem_ready are both high in the cycle before it.
  // o_mem_ready depends only on the registered FIFO count, so there is no
  // combinational path from i_mem_valid. The ALU path has no ready signal.
  // ALU results must be taken in the cycle they are presented.

  logic [DATA_WIDTH-1:0] fifo_data [BUF_DEPTH];
  logic [AW-1:0]         fifo_addr [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  empty, full;

  logic                  mem_acc, direct_sel, fifo_sel, enq, deq;
  logic                  wb_any, wb_mem;
  logic [AW-1:0]         wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  rw_from_mem;

  logic                  issue_acc;
  logic [NUM_REGISTER-1:0] set_vec, clr_vec;
  logic                  haz1, haz2;

  assign empty       = (count == '0);
  assign full        = (count == (PW+1)'(BUF_DEPTH));
  assign o_mem_ready = !full;

  // Source priority: ALU, then FIFO head, then the memory input directly.
  // The direct path is used only when nothing older is queued.
  always_comb begin
    mem_acc    = i_mem_valid && o_mem_ready;
    fifo_sel   = !i_alu_valid && !empty;
    direct_sel = !i_alu_valid && empty && mem_acc;
    enq        = mem_acc && !direct_sel;
    deq        = fifo_sel;
    wb_any     = i_alu_valid || fifo_sel || direct_sel;
    wb_mem     = fifo_sel || direct_sel;
    wb_addr    = i_mem_rd_addr;
    wb_data    = i_mem_data;
    if (i_alu_valid) begin
      wb_addr = i_alu_rd_addr;
      wb_data = i_alu_data;
    end else if (fifo_sel) begin
      wb_addr = fifo_addr[rd_ptr];
      wb_data = fifo_data[rd_ptr];
    end
  end

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      fifo_data[wr_ptr] <= i_mem_data;
      fifo_addr[wr_ptr] <= i_mem_rd_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write port. A write to x0 still consumes its source but raises no enable.
  // In idle cycles the address and data hold their previous values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rw        <= 1'b0;
      o_rd_addr   <= '0;
      o_rd        <= '0;
      rw_from_mem <= 1'b0;
    end else if (wb_any) begin
      o_rw        <= (wb_addr != '0);
      o_rd_addr   <= wb_addr;
      o_rd        <= wb_data;
      rw_from_mem <= wb_mem;
    end else begin
      o_rw        <= 1'b0;
      rw_from_mem <= 1'b0;
    end
  end

  // Scoreboard. A bit clears once its load result has been written. ALU
  // writes never clear a bit. When a set and a clear hit the same bit, the
  // set wins.
  assign issue_acc = i_issue_valid && !o_stall;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_acc && i_issue_rd_addr != '0) set_vec[i_issue_rd_addr] = 1'b1;
    if (o_rw && rw_from_mem)                clr_vec[o_rd_addr]       = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_pending <= '0;
    else       o_pending <= (o_pending & ~clr_vec) | set_vec;
  end

  always_comb begin
    haz1 = o_pending[i_rs1_addr] && (i_rs1_addr != '0);
    haz2 = o_pending[i_rs2_addr] && (i_rs2_addr != '0);
`ifdef WB_BYPASS_EN
    o_fwd1_valid = o_rw && (o_rd_addr == i_rs1_addr) && (i_rs1_addr != '0);
    o_fwd2_valid = o_rw && (o_rd_addr == i_rs2_addr) && (i_rs2_addr != '0);
    o_fwd_data   = o_rd;
    haz1         = haz1 && !o_fwd1_valid;
    haz2         = haz2 && !o_fwd2_valid;
`endif
    // The last term is a WAW stall: the same destination is still in flight.
    o_stall = haz1 || haz2 || (i_issue_valid && o_pending[i_issue_rd_addr]);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed bench for wb_arbiter. Each stimulus step pushes the write it
//   expects ({cycle, rd_addr, data}) into exp_q. A negedge monitor pops one
//   entry per observed o_rw pulse and compares it. Scoreboard and stall
//   behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int EW = 32 + AW + DW;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_issue_valid;
  logic [AW-1:0] i_issue_rd_addr, i_rs1_addr, i_rs2_addr;
  logic          o_stall;
  logic          i_alu_valid;
  logic [AW-1:0] i_alu_rd_addr;
  logic [DW-1:0] i_alu_data;
  logic          i_mem_valid;
  logic [AW-1:0] i_mem_rd_addr;
  logic [DW-1:0] i_mem_data;
  logic          o_mem_ready;
  logic          o_rw;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] o_rd;
  logic [NR-1:0] o_pending;
`ifdef WB_BYPASS_EN
  logic          o_fwd1_valid, o_fwd2_valid;
  logic [DW-1:0] o_fwd_data;
`endif

  wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTER(NR), .BUF_DEPTH(2)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_issue_valid(i_issue_valid), .i_issue_rd_addr(i_issue_rd_addr),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .o_stall(o_stall),
    .i_alu_valid(i_alu_valid), .i_alu_rd_addr(i_alu_rd_addr), .i_alu_data(i_alu_data),
    .i_mem_valid(i_mem_valid), .i_mem_rd_addr(i_mem_rd_addr), .i_mem_data(i_mem_data),
    .o_mem_ready(o_mem_ready), .o_rw(o_rw), .o_rd_addr(o_rd_addr), .o_rd(o_rd),
    .o_pending(o_pending)
`ifdef WB_BYPASS_EN
    , .o_fwd1_valid(o_fwd1_valid), .o_fwd2_valid(o_fwd2_valid), .o_fwd_data(o_fwd_data)
`endif
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [31:0] c32;
    c32 = c;
    exp_q.push_back({c32, a, d});
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [31:0]   c32;
    if (o_rw) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {59'd0, o_rd_addr}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        c32 = cyc;
        chk("write_cycle", {32'd0, c32}, {32'd0, e[EW-1 -: 32]});
        chk("write_addr", {59'd0, o_rd_addr}, {59'd0, e[DW +: AW]});
        chk("write_data", {32'd0, o_rd}, {32'd0, e[DW-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_issue_valid = 1'b0;
    i_alu_valid   = 1'b0;
    i_mem_valid   = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    i_issue_valid   = 1'b1;
    i_issue_rd_addr = rd;
    tick();
    i_issue_valid   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] mem_rd [4];
  logic [DW-1:0] mem_dt [4];
  logic [NR-1:0] snap;
  int base, m;
  logic acc;

  initial begin
    i_rst = 1'b1;
    idle();
    i_issue_rd_addr = '0; i_rs1_addr = '0; i_rs2_addr = '0;
    i_alu_rd_addr = '0; i_alu_data = '0; i_mem_rd_addr = '0; i_mem_data = '0;
    repeat (3) tick();

    chk("reset_rw", {63'd0, o_rw}, 64'd0);
    chk("reset_rd_addr", {59'd0, o_rd_addr}, 64'd0);
    chk("reset_rd", {32'd0, o_rd}, 64'd0);
    chk("reset_pending", {32'd0, o_pending}, 64'd0);
    chk("reset_mem_ready", {63'd0, o_mem_ready}, 64'd1);
    chk("reset_stall", {63'd0, o_stall}, 64'd0);
    i_rst = 1'b0;
    tick();

    // ALU write, then ALU write to x0.
    i_alu_valid = 1'b1; i_alu_rd_addr = 5'd3; i_alu_data = 32'h1234_5678;
    push_exp(cyc + 1, 5'd3, 32'h1234_5678);
    tick();
    i_alu_rd_addr = 5'd0; i_alu_data = 32'h5555_5555;
    tick();
    i_alu_valid = 1'b0;
    chk("alu_x0_rw", {63'd0, o_rw}, 64'd0);
    tick();

    // RAW stall on load rd=7, released after the direct memory write.
    issue(5'd7);
    chk("pending7_set", {63'd0, o_pending[7]}, 64'd1);
    i_rs1_addr = 5'd7;
    #1;
    chk("raw_stall", {63'd0, o_stall}, 64'd1);
    i_mem_valid = 1'b1; i_mem_rd_addr = 5'd7; i_mem_data = 32'hDEAD_BEEF;
    push_exp(cyc + 1, 5'd7, 32'hDEAD_BEEF);
    tick();
    i_mem_valid = 1'b0;
    #1;
    chk("pending7_in_write_cycle", {63'd0, o_pending[7]}, 64'd1);
`ifdef WB_BYPASS_EN
    chk("bypass_stall", {63'd0, o_stall}, 64'd0);
    chk("bypass_fwd1", {63'd0, o_fwd1_valid}, 64'd1);
    chk("bypass_data", {32'd0, o_fwd_data}, 64'hDEAD_BEEF);
`else
    chk("stall_in_write_cycle", {63'd0, o_stall}, 64'd1);
`endif
    tick();
    chk("pending7_cleared", {63'd0, o_pending[7]}, 64'd0);
    chk("stall_released", {63'd0, o_stall}, 64'd0);
    i_rs1_addr = 5'd0;

    // ALU burst against three memory results.
    issue(5'd9); issue(5'd10); issue(5'd11);
    chk("pending_9_11_set", {61'd0, o_pending[11:9]}, 64'd7);
    mem_rd[0] = 5'd9;  mem_dt[0] = 32'h0000_0009;
    mem_rd[1] = 5'd10; mem_dt[1] = 32'h0000_000A;
    mem_rd[2] = 5'd11; mem_dt[2] = 32'h0000_000B;
    mem_rd[3] = 5'd0;  mem_dt[3] = 32'h0;
    base = cyc;
    for (int i = 0; i < 4; i++) push_exp(base + i + 1, AW'(20 + i), 32'hA000_0000 + i);
    push_exp(base + 5, 5'd9, 32'h0000_0009);
    push_exp(base + 6, 5'd10, 32'h0000_000A);
    push_exp(base + 7, 5'd11, 32'h0000_000B);
    m = 0;
    for (int i = 0; i < 7; i++) begin
      i_alu_valid   = (i < 4);
      i_alu_rd_addr = AW'(20 + i);
      i_alu_data    = 32'hA000_0000 + i;
      i_mem_valid   = (m < 3);
      i_mem_rd_addr = mem_rd[m];
      i_mem_data    = mem_dt[m];
      if (i == 2) chk("burst_ready_low", {63'd0, o_mem_ready}, 64'd0);
      if (i == 5) chk("burst_ready_back", {63'd0, o_mem_ready}, 64'd1);
      acc = i_mem_valid && o_mem_ready;
      tick();
      if (acc) m++;
    end
    idle();
    chk("burst_all_accepted", 64'(m), 64'd3);
    repeat (3) tick();
    chk("pending_9_11_clear", {61'd0, o_pending[11:9]}, 64'd0);

    // Issue rd=4 in the cycle its earlier load is written back.
    issue(5'd4);
    i_mem_valid = 1'b1; i_mem_rd_addr = 5'd4; i_mem_data = 32'h0000_0444;
    push_exp(cyc + 1, 5'd4, 32'h0000_0444);
    tick();
    i_mem_valid = 1'b0;
    i_issue_valid = 1'b1; i_issue_rd_addr = 5'd4;
    #1;
    chk("issue4_waw_in_clear_cycle", {63'd0, o_stall}, 64'd1);
    tick();
    tick();
    i_issue_valid = 1'b0;
    chk("pending4_after_reissue", {63'd0, o_pending[4]}, 64'd1);

    // WAW stall: the scoreboard must not change.
    issue(5'd7);
    i_issue_valid = 1'b1; i_issue_rd_addr = 5'd7;
    #1;
    chk("waw_stall", {63'd0, o_stall}, 64'd1);
    snap = o_pending;
    tick();
    i_issue_valid = 1'b0;
    chk("waw_pending_unchanged", {32'd0, o_pending}, {32'd0, snap});

    // Reset mid-stream with two FIFO entries and pending[5] set.
    issue(5'd5);
    i_alu_valid = 1'b1; i_alu_rd_addr = 5'd2; i_alu_data = 32'h0000_0001;
    i_mem_valid = 1'b1; i_mem_rd_addr = 5'd5; i_mem_data = 32'h0000_0055;
    push_exp(cyc + 1, 5'd2, 32'h0000_0001);
    tick();
    i_alu_data = 32'h0000_0002;
    i_mem_rd_addr = 5'd6; i_mem_data = 32'h0000_0066;
    push_exp(cyc + 1, 5'd2, 32'h0000_0002);
    tick();
    idle();
    chk("fill_ready_low", {63'd0, o_mem_ready}, 64'd0);
    chk("fill_pending5", {63'd0, o_pending[5]}, 64'd1);
    @(negedge clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("async_reset_rw", {63'd0, o_rw}, 64'd0);
    chk("async_reset_pending", {32'd0, o_pending}, 64'd0);
    repeat (2) tick();
    i_rst = 1'b0;
    chk("post_reset_ready", {63'd0, o_mem_ready}, 64'd1);
    repeat (3) tick();
    i_mem_valid = 1'b1; i_mem_rd_addr = 5'd8; i_mem_data = 32'h0000_0888;
    push_exp(cyc + 1, 5'd8, 32'h0000_0888);
    tick();
    idle();
    repeat (3) tick();

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
